// File: rtl/writeback_arbiter_if.sv
// Bundle between the ALU/load producers, the writeback arbiter and the register-file write port.
interface writeback_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int QDEPTH = 2
) ();
   localparam int CNT_W = $clog2(QDEPTH) + 1;

   logic                 alu_valid;
   logic [ADDR_W-1:0]    alu_rd;
   logic [DATA_W-1:0]    alu_data;
   logic                 mem_valid;
   logic                 mem_ready;
   logic [ADDR_W-1:0]    mem_rd;
   logic [DATA_W-1:0]    mem_data;
   logic                 reg_write;
   logic [ADDR_W-1:0]    write_reg;
   logic [DATA_W-1:0]    write_data;
   logic [2**ADDR_W-1:0] busy_mask;
   logic [CNT_W-1:0]     queue_count;

   // Producer / register-file side.
   modport master (
      output alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data,
      input  mem_ready,
      input  reg_write, write_reg, write_data, busy_mask, queue_count
   );

   // Arbiter side.
   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data,
      output mem_ready,
      output reg_write, write_reg, write_data, busy_mask, queue_count
   );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges the ALU result and buffered load results onto the single register-file write port,
// dropping r0 writes and killing older queued loads superseded by a newer ALU write.
module writeback_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int QDEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   writeback_arbiter_if.slave  bus
);
   localparam int CNT_W = $clog2(QDEPTH) + 1;
   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

   // Queue is kept compacted with the head in slot 0, so killed entries free their slot at once
   // and the head is always a live entry.
   logic [ADDR_W-1:0] rd_q   [QDEPTH];
   logic [ADDR_W-1:0] rd_d   [QDEPTH];
   logic [DATA_W-1:0] data_q [QDEPTH];
   logic [DATA_W-1:0] data_d [QDEPTH];
   logic [CNT_W-1:0]  count_q, count_d;

   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;

   logic              alu_fire;
   logic              pop;
   logic              mem_ready;
   logic              push;
   logic [CNT_W-1:0]  idx;
   logic [2**ADDR_W-1:0] busy_mask;

   assign alu_fire  = bus.alu_valid && (bus.alu_rd != '0);
   assign mem_ready = rst_n && (count_q < CNT_W'(QDEPTH));
   assign pop       = !alu_fire && (count_q != '0);
   // Loads accepted alongside an ALU write to the same register are already stale.
   assign push      = bus.mem_valid && mem_ready && (bus.mem_rd != '0) &&
                      !(alu_fire && (bus.mem_rd == bus.alu_rd));

   always_comb begin
      rd_d   = rd_q;
      data_d = data_q;
      idx    = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         if ((CNT_W'(i) < count_q) &&
             !(alu_fire && (rd_q[i] == bus.alu_rd)) &&
             !(pop && (i == 0))) begin
            rd_d[idx[PTR_W-1:0]]   = rd_q[i];
            data_d[idx[PTR_W-1:0]] = data_q[i];
            idx = idx + CNT_W'(1);
         end
      end
      if (push) begin
         rd_d[idx[PTR_W-1:0]]   = bus.mem_rd;
         data_d[idx[PTR_W-1:0]] = bus.mem_data;
         idx = idx + CNT_W'(1);
      end
      count_d = idx;
   end

   always_comb begin
      reg_write_d  = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (alu_fire) begin
         reg_write_d  = 1'b1;
         write_reg_d  = bus.alu_rd;
         write_data_d = bus.alu_data;
      end else if (pop) begin
         reg_write_d  = 1'b1;
         write_reg_d  = rd_q[0];
         write_data_d = data_q[0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
         count_q      <= '0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         rd_q         <= rd_d;
         data_q       <= data_d;
         count_q      <= count_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   always_comb begin
      busy_mask = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (CNT_W'(i) < count_q) busy_mask[rd_q[i]] = 1'b1;
      end
      if (reg_write_q) busy_mask[write_reg_q] = 1'b1;
      busy_mask[0] = 1'b0;
   end

   assign bus.mem_ready   = mem_ready;
   assign bus.reg_write   = reg_write_q;
   assign bus.write_reg   = write_reg_q;
   assign bus.write_data  = write_data_q;
   assign bus.busy_mask   = busy_mask;
   assign bus.queue_count = count_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector table plus a mid-drain asynchronous reset sequence for writeback_arbiter.
module tb_writeback_arbiter;
   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 0;

   writeback_arbiter_if #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2)) ifc ();

   writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        av;
      logic [4:0]  ard;
      logic [31:0] adat;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] mdat;
      logic        rw;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic [31:0] busy;
      logic [1:0]  qc;
      logic        mr;
   } vec_t;

   vec_t vq[$];

   function automatic logic [31:0] b(input int n);
      return 32'h1 << n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
      ifc.alu_valid = av;
      ifc.alu_rd    = ard;
      ifc.alu_data  = adat;
      ifc.mem_valid = mv;
      ifc.mem_rd    = mrd;
      ifc.mem_data  = mdat;
   endtask

   task automatic chk_all(input string tag, input logic rw, input logic [4:0] wr,
                          input logic [31:0] wd, input logic [31:0] busy,
                          input logic [1:0] qc, input logic mr);
      chk({tag, ".reg_write"},   32'(ifc.reg_write),   32'(rw));
      chk({tag, ".write_reg"},   32'(ifc.write_reg),   32'(wr));
      chk({tag, ".write_data"},  ifc.write_data,       wd);
      chk({tag, ".busy_mask"},   ifc.busy_mask,        busy);
      chk({tag, ".queue_count"}, 32'(ifc.queue_count), 32'(qc));
      chk({tag, ".mem_ready"},   32'(ifc.mem_ready),   32'(mr));
   endtask

   // A write to r0 must never reach the register file.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         checks++;
         if (ifc.reg_write === 1'b1 && ifc.write_reg === 5'd0) begin
            errors++;
            $display("FAIL r0_write: write_reg=%0d with reg_write=1 (t=%0t)", ifc.write_reg, $time);
         end
      end
   end

   initial begin
      //           av  ard    adat       mv  mrd    mdat        rw  wr     wd         busy                     qc    mr
      vq.push_back('{1, 5'd8,  32'h5,    0, 5'd0,  32'h0,      1, 5'd8,  32'h5,    b(8),                    2'd0, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd8,  32'h5,    32'h0,                   2'd0, 1});
      vq.push_back('{0, 5'd0,  32'h0,    1, 5'd9,  32'h1234,   0, 5'd8,  32'h5,    b(9),                    2'd1, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      1, 5'd9,  32'h1234, b(9),                    2'd0, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd9,  32'h1234, 32'h0,                   2'd0, 1});
      vq.push_back('{1, 5'd25, 32'hA1,   1, 5'd10, 32'h100,    1, 5'd25, 32'hA1,   b(25)|b(10),             2'd1, 1});
      vq.push_back('{1, 5'd25, 32'hA2,   1, 5'd11, 32'h110,    1, 5'd25, 32'hA2,   b(25)|b(10)|b(11),       2'd2, 0});
      vq.push_back('{1, 5'd25, 32'hA3,   1, 5'd12, 32'h120,    1, 5'd25, 32'hA3,   b(25)|b(10)|b(11),       2'd2, 0});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      1, 5'd10, 32'h100,  b(10)|b(11),             2'd1, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      1, 5'd11, 32'h110,  b(11),                   2'd0, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd11, 32'h110,  32'h0,                   2'd0, 1});
      vq.push_back('{1, 5'd20, 32'h20,   1, 5'd10, 32'hBAD,    1, 5'd20, 32'h20,   b(20)|b(10),             2'd1, 1});
      vq.push_back('{1, 5'd10, 32'h7,    0, 5'd0,  32'h0,      1, 5'd10, 32'h7,    b(10),                   2'd0, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd10, 32'h7,    32'h0,                   2'd0, 1});
      vq.push_back('{1, 5'd13, 32'h33,   1, 5'd13, 32'hDEAD,   1, 5'd13, 32'h33,   b(13),                   2'd0, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd13, 32'h33,   32'h0,                   2'd0, 1});
      vq.push_back('{1, 5'd21, 32'h21,   1, 5'd12, 32'h1200,   1, 5'd21, 32'h21,   b(21)|b(12),             2'd1, 1});
      vq.push_back('{1, 5'd0,  32'hFF,   0, 5'd0,  32'h0,      1, 5'd12, 32'h1200, b(12),                   2'd0, 1});
      vq.push_back('{1, 5'd0,  32'hFF,   1, 5'd0,  32'h77,     0, 5'd12, 32'h1200, 32'h0,                   2'd0, 1});
      vq.push_back('{0, 5'd0,  32'h0,    1, 5'd14, 32'h14,     0, 5'd12, 32'h1200, b(14),                   2'd1, 1});
      vq.push_back('{0, 5'd0,  32'h0,    1, 5'd15, 32'h15,     1, 5'd14, 32'h14,   b(14)|b(15),             2'd1, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      1, 5'd15, 32'h15,   b(15),                   2'd0, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd15, 32'h15,   32'h0,                   2'd0, 1});
      vq.push_back('{1, 5'd1,  32'h1,    1, 5'd16, 32'h16,     1, 5'd1,  32'h1,    b(1)|b(16),              2'd1, 1});
      vq.push_back('{1, 5'd2,  32'h2,    1, 5'd17, 32'h17,     1, 5'd2,  32'h2,    b(2)|b(16)|b(17),        2'd2, 0});
      vq.push_back('{1, 5'd16, 32'h60,   1, 5'd18, 32'h18,     1, 5'd16, 32'h60,   b(16)|b(17),             2'd1, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      1, 5'd17, 32'h17,   b(17),                   2'd0, 1});
      vq.push_back('{0, 5'd0,  32'h0,    0, 5'd0,  32'h0,      0, 5'd17, 32'h17,   32'h0,                   2'd0, 1});

      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      rst_n = 1'b0;
      #2;
      chk_all("reset", 0, 5'd0, 32'h0, 32'h0, 2'd0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk_all("post_reset", 0, 5'd0, 32'h0, 32'h0, 2'd0, 1);
      mon_en = 1;

      foreach (vq[k]) begin
         drive(vq[k].av, vq[k].ard, vq[k].adat, vq[k].mv, vq[k].mrd, vq[k].mdat);
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", k), vq[k].rw, vq[k].wr, vq[k].wd, vq[k].busy, vq[k].qc, vq[k].mr);
      end

      // Two loads queued behind a busy ALU, then reset lands mid-cycle before they drain.
      drive(1, 5'd3, 32'h3, 1, 5'd18, 32'h18);
      @(posedge clk); #1;
      drive(1, 5'd4, 32'h4, 1, 5'd19, 32'h19);
      @(posedge clk); #1;
      chk_all("rst_pre", 1, 5'd4, 32'h4, b(4)|b(18)|b(19), 2'd2, 0);
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      #3 rst_n = 1'b0;
      #1;
      chk_all("rst_async", 0, 5'd0, 32'h0, 32'h0, 2'd0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk_all("rst_hold", 0, 5'd0, 32'h0, 32'h0, 2'd0, 0);
      #3 rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk_all($sformatf("rst_after%0d", c), 0, 5'd0, 32'h0, 32'h0, 2'd0, 1);
      end

      // A fresh load after reset still takes the normal two-cycle path.
      drive(0, 5'd0, 32'h0, 1, 5'd22, 32'hCAFE);
      @(posedge clk); #1;
      drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      chk_all("fresh_q", 0, 5'd0, 32'h0, b(22), 2'd1, 1);
      @(posedge clk); #1;
      chk_all("fresh_wr", 1, 5'd22, 32'hCAFE, b(22), 2'd0, 1);

      mon_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
